instr_issue: RTL and testbench
==============================

# instr_issue

Instruction fetch-and-issue front end: drives the cpu's instruction inputs that the bench currently drives by hand. It fetches 32-bit RV32I words from instruction memory over a req/ack interface and decodes OP-IMM instructions into `op`, `dst`, `src1` and `val2`. It presents each decoded instruction to the cpu through a valid/ready handshake, and halts on ECALL/EBREAK or on an illegal word.

## Interface
Parameters:
- `RESET_PC`, 0, PC value after reset and after restart.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin fetching at `RESET_PC`; honoured only in IDLE or HALT.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; word-aligned.
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `issue_valid`  out  1  decoded instruction presented.
- `issue_ready`  in  1  cpu accepts the instruction.
- `op`  out  AluOp  ALU operation.
- `dst`, `src1`  out  RegAddress  destination register (rd) and source register (rs1).
- `val2`  out  Reg  immediate operand.
- `pc`  out  32  address of the instruction being fetched or issued.
- `halted`  out  1  stopped on ECALL/EBREAK.
- `illegal`  out  1  stopped on an undecodable word.

## Operation
- FSM states: IDLE, FETCH, ISSUE, HALT.
- IDLE:
  - On `start`, go to FETCH.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ack`.
  - On ack with a legal OP-IMM word: go to ISSUE.
  - On ack with ECALL (0x00000073) or EBREAK (0x00100073): go to HALT, `halted`=1.
  - On ack with any other word: go to HALT, `illegal`=1.
- ISSUE:
  - `issue_valid`=1; outputs held stable while `issue_ready`=0.
  - On handshake (`issue_valid` && `issue_ready`): `pc`+=4, go to FETCH.
- HALT:
  - No requests. `pc` holds the address of the halting word.
  - On `start`: clear both flags, `pc`=`RESET_PC`, go to FETCH.
- Decode (opcode 0010011, funct3):
  - 000 → ADD; 010 → SLT; 011 → SLTU; 100 → XOR; 110 → OR; 111 → AND.
  - `val2` = imm[11:0] sign-extended to 32 bits.
  - 001 with funct7=0000000 → SHL.
  - 101 with funct7=0000000 → SHR; 101 with funct7=0100000 → SRA.
  - For shifts, `val2` = zero-extended shamt[4:0].
  - Any other funct7 on a shift encoding is illegal.
- Field mapping: `dst`=rd, `src1`=rs1. NOP (ADDI x0,x0,0) issues normally.
- `pc` wraps modulo 2^32.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `issue_valid`=0, `op`=ADD, `dst`=0, `src1`=0, `val2`=0, `pc`=`RESET_PC`, `halted`=0, `illegal`=0. State IDLE.
- Reset takes effect immediately, mid-transaction included. An outstanding request is abandoned; an `imem_ack` arriving outside FETCH is ignored.
- The ack may arrive in the first cycle of `imem_req` (combinational memory).
- Minimum latency without prefetch: ack cycle → `issue_valid` next cycle, i.e. 2 cycles per instruction.
- After a handshake, `issue_valid` drops for at least one cycle (non-prefetch).
- `start` is ignored in FETCH and ISSUE.

## Configuration
- `INSTR_ISSUE_PREFETCH_EN` defined:
  - While in ISSUE, the block fetches `pc`+4 into a one-entry buffer.
  - On handshake with the buffer full, the buffered word is decoded directly. `issue_valid` stays high, giving back-to-back issue at 1 instruction/cycle.
  - If the prefetch ack lands in the handshake cycle, `imem_rdata` is used directly.
  - If the prefetch is still outstanding at the handshake, go to FETCH with `imem_req` held.
  - A buffered halting or illegal word goes to HALT, with `pc` set to its address.
- Undefined: no request is issued while in ISSUE.

## Structure
- `types.sv` holds:
  - AluOp, with SLT, SLTU, SHR, SRA, XOR, OR, AND added where missing.
  - RegAddress, Reg.
  - Constants `OPC_OP_IMM`, `INSN_ECALL`, `INSN_EBREAK`.
- One combinational sub-module, `instr_decode`: word → {legal, is_halt, op, dst, src1, val2}. Shared by the fetch and buffer paths.

## Test plan
- Reset, `start`, memory[0]=0x00A00093, combinational ack, `issue_ready`=1 → `issue_valid` in cycle 2 with op=ADD, dst=1, src1=0, val2=10; `pc` 0→4.
- 0x00309093 → SHL, dst=1, src1=1, val2=3. 0x40725293 → SRA, dst=5, src1=4, val2=7.
- 0xFFF08113 → ADD, dst=2, src1=1, val2=0xFFFFFFFF.
- `issue_ready`=0 for 5 cycles → all outputs stable, `pc` unchanged, `imem_req`=0 (non-prefetch build).
- ECALL at 0x10 → `halted`=1, `pc`=0x10, no further requests. 0x00000033 → `illegal`=1. `start` → restart at 0.
- `rst` raised while a request is outstanding (ack delay 3) → outputs take reset values immediately and the late ack is ignored. Prefetch build, `issue_ready`=1 → four consecutive `issue_valid` cycles.

Source files
------------

// File: rtl/types.sv
// rtl/types.sv - shared ALU op, register and encoding types for the instruction front end
package types;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SLT  = 4'd1,
        SLTU = 4'd2,
        XOR  = 4'd3,
        OR   = 4'd4,
        AND  = 4'd5,
        SHL  = 4'd6,
        SHR  = 4'd7,
        SRA  = 4'd8
    } AluOp;

    typedef logic [4:0]  RegAddress;
    typedef logic [31:0] Reg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } issue_state_t;

    localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational RV32I OP-IMM decoder with halt detection
module instr_decode
    import types::*;
(
    input  logic [31:0] word,
    output logic        legal,
    output logic        is_halt,
    output AluOp        op,
    output RegAddress   dst,
    output RegAddress   src1,
    output Reg          val2
);

    logic [2:0] funct3;
    logic [6:0] funct7;
    Reg         imm_sext;
    Reg         shamt;

    assign funct3   = word[14:12];
    assign funct7   = word[31:25];
    assign imm_sext = {{20{word[31]}}, word[31:20]};
    assign shamt    = {27'd0, word[24:20]};

    always_comb begin
        legal   = 1'b0;
        is_halt = 1'b0;
        op      = ADD;
        dst     = word[11:7];
        src1    = word[19:15];
        val2    = imm_sext;
        if (word == INSN_ECALL || word == INSN_EBREAK) begin
            is_halt = 1'b1;
        end else if (word[6:0] == OPC_OP_IMM) begin
            case (funct3)
                3'b000: begin legal = 1'b1; op = ADD;  end
                3'b010: begin legal = 1'b1; op = SLT;  end
                3'b011: begin legal = 1'b1; op = SLTU; end
                3'b100: begin legal = 1'b1; op = XOR;  end
                3'b110: begin legal = 1'b1; op = OR;   end
                3'b111: begin legal = 1'b1; op = AND;  end
                3'b001: begin
                    if (funct7 == 7'b0000000) begin
                        legal = 1'b1;
                        op    = SHL;
                        val2  = shamt;
                    end
                end
                3'b101: begin
                    // funct7 selects logical vs arithmetic; anything else is reserved
                    if (funct7 == 7'b0000000) begin
                        legal = 1'b1;
                        op    = SHR;
                        val2  = shamt;
                    end else if (funct7 == 7'b0100000) begin
                        legal = 1'b1;
                        op    = SRA;
                        val2  = shamt;
                    end
                end
                default: begin
                    legal = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_issue.sv
// rtl/instr_issue.sv - fetch/decode/issue front end; INSTR_ISSUE_PREFETCH_EN adds a one-word prefetch buffer
module instr_issue
    import types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        issue_valid,
    input  logic        issue_ready,
    output AluOp        op,
    output RegAddress   dst,
    output RegAddress   src1,
    output Reg          val2,
    output logic [31:0] pc,
    output logic        halted,
    output logic        illegal
);

    issue_state_t state, state_nxt;
    logic [31:0]  pc_q, pc_nxt;
    logic         halted_q, halted_nxt;
    logic         illegal_q, illegal_nxt;
    logic         load_dec;
    AluOp         op_q;
    RegAddress    dst_q, src1_q;
    Reg           val2_q;

    logic [31:0]  dec_word;
    logic         dec_legal, dec_is_halt;
    AluOp         dec_op;
    RegAddress    dec_dst, dec_src1;
    Reg           dec_val2;

`ifdef INSTR_ISSUE_PREFETCH_EN
    logic         buf_full, buf_full_nxt;
    logic [31:0]  buf_word, buf_word_nxt;
`endif

    // One decoder serves both the fetch path and the prefetch buffer path
    instr_decode u_decode (
        .word    (dec_word),
        .legal   (dec_legal),
        .is_halt (dec_is_halt),
        .op      (dec_op),
        .dst     (dec_dst),
        .src1    (dec_src1),
        .val2    (dec_val2)
    );

    assign pc      = pc_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign op      = op_q;
    assign dst     = dst_q;
    assign src1    = src1_q;
    assign val2    = val2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc_q      <= RESET_PC;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            op_q      <= ADD;
            dst_q     <= '0;
            src1_q    <= '0;
            val2_q    <= '0;
`ifdef INSTR_ISSUE_PREFETCH_EN
            buf_full  <= 1'b0;
            buf_word  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            pc_q      <= pc_nxt;
            halted_q  <= halted_nxt;
            illegal_q <= illegal_nxt;
            if (load_dec) begin
                op_q   <= dec_op;
                dst_q  <= dec_dst;
                src1_q <= dec_src1;
                val2_q <= dec_val2;
            end
`ifdef INSTR_ISSUE_PREFETCH_EN
            buf_full  <= buf_full_nxt;
            buf_word  <= buf_word_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_q;
        halted_nxt  = halted_q;
        illegal_nxt = illegal_q;
        load_dec    = 1'b0;
        imem_req    = 1'b0;
        imem_addr   = pc_q;
        issue_valid = 1'b0;
        dec_word    = imem_rdata;
`ifdef INSTR_ISSUE_PREFETCH_EN
        buf_full_nxt = buf_full;
        buf_word_nxt = buf_word;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_nxt    = RESET_PC;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (dec_legal) begin
                        load_dec  = 1'b1;
                        state_nxt = S_ISSUE;
                    end else if (dec_is_halt) begin
                        halted_nxt = 1'b1;
                        state_nxt  = S_HALT;
                    end else begin
                        illegal_nxt = 1'b1;
                        state_nxt   = S_HALT;
                    end
                end
            end
            S_ISSUE: begin
                issue_valid = 1'b1;
`ifdef INSTR_ISSUE_PREFETCH_EN
                imem_req  = !buf_full;
                imem_addr = pc_q + 32'd4;
                if (buf_full) begin
                    dec_word = buf_word;
                end
                if (issue_ready) begin
                    pc_nxt       = pc_q + 32'd4;
                    buf_full_nxt = 1'b0;
                    if (buf_full || imem_ack) begin
                        if (dec_legal) begin
                            load_dec = 1'b1;
                        end else if (dec_is_halt) begin
                            halted_nxt = 1'b1;
                            state_nxt  = S_HALT;
                        end else begin
                            illegal_nxt = 1'b1;
                            state_nxt   = S_HALT;
                        end
                    end else begin
                        // Prefetch still in flight: FETCH keeps the same request alive
                        state_nxt = S_FETCH;
                    end
                end else if (imem_ack && !buf_full) begin
                    buf_full_nxt = 1'b1;
                    buf_word_nxt = imem_rdata;
                end
`else
                if (issue_ready) begin
                    pc_nxt    = pc_q + 32'd4;
                    state_nxt = S_FETCH;
                end
`endif
            end
            S_HALT: begin
                if (start) begin
                    halted_nxt  = 1'b0;
                    illegal_nxt = 1'b0;
                    pc_nxt      = RESET_PC;
                    state_nxt   = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_issue.sv
// tb/tb_instr_issue.sv - randomized self-checking bench for instr_issue against a program-level model
module tb_instr_issue;
    import types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        issue_valid;
    logic        issue_ready;
    AluOp        op;
    RegAddress   dst;
    RegAddress   src1;
    Reg          val2;
    logic [31:0] pc;
    logic        halted;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_issue dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .op          (op),
        .dst         (dst),
        .src1        (src1),
        .val2        (val2),
        .pc          (pc),
        .halted      (halted),
        .illegal     (illegal)
    );

    // Memory: acks after ack_delay cycles of continuous request
    logic [31:0] mem [0:63];
    int          ack_delay;
    int          ack_cnt;
    logic        force_ack;

    assign imem_ack   = force_ack | (imem_req && (ack_cnt >= ack_delay));
    assign imem_rdata = mem[imem_addr[7:2]];

    always @(posedge clk or posedge rst) begin
        if (rst)                        ack_cnt <= 0;
        else if (imem_req && !imem_ack) ack_cnt <= ack_cnt + 1;
        else                            ack_cnt <= 0;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] op;
        logic [31:0] rd;
        logic [31:0] rs1;
        logic [31:0] v2;
    } exp_t;

    exp_t        q[$];
    logic [31:0] exp_stop_pc;
    int          exp_kind;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Returns 0 for an issuable word, 1 for ECALL/EBREAK, 2 for anything undecodable
    function automatic int model_decode(input logic [31:0] w, output exp_t e);
        int unsigned f3;
        int unsigned f7;
        int unsigned opc;
        f3    = (w >> 12) & 7;
        f7    = w >> 25;
        opc   = w & 32'h7f;
        e.pc  = 0;
        e.op  = 32'(ADD);
        e.rd  = (w >> 7) & 31;
        e.rs1 = (w >> 15) & 31;
        e.v2  = $signed(w) >>> 20;
        if (w == 32'h0000_0073 || w == 32'h0010_0073) return 1;
        if (opc != 32'h13) return 2;
        case (f3)
            0: e.op = 32'(ADD);
            2: e.op = 32'(SLT);
            3: e.op = 32'(SLTU);
            4: e.op = 32'(XOR);
            6: e.op = 32'(OR);
            7: e.op = 32'(AND);
            1: begin
                if (f7 != 0) return 2;
                e.op = 32'(SHL);
                e.v2 = (w >> 20) & 31;
            end
            default: begin
                if (f7 == 0)       e.op = 32'(SHR);
                else if (f7 == 32) e.op = 32'(SRA);
                else return 2;
                e.v2 = (w >> 20) & 31;
            end
        endcase
        return 0;
    endfunction

    task automatic build_expect();
        logic [31:0] p;
        exp_t        e;
        int          k;
        q.delete();
        p = 0;
        exp_kind = 0;
        exp_stop_pc = 0;
        for (int i = 0; i < 80; i++) begin
            k = model_decode(mem[p[7:2]], e);
            if (k == 0) begin
                e.pc = p;
                q.push_back(e);
                p = p + 4;
            end else begin
                exp_kind    = k;
                exp_stop_pc = p;
                break;
            end
        end
    endtask

    function automatic logic [31:0] rand_legal();
        logic [31:0] w;
        logic [31:0] r;
        w = $urandom;
        r = $urandom;
        w[6:0]   = 7'h13;
        w[14:12] = r[2:0];
        if (r[2:0] == 3'b001) w[31:25] = 7'b0000000;
        if (r[2:0] == 3'b101) w[31:25] = r[3] ? 7'b0100000 : 7'b0000000;
        return w;
    endfunction

    task automatic fill_halt();
        for (int i = 0; i < 64; i++) mem[i] = INSN_ECALL;
    endtask

    task automatic gen_random();
        int          n;
        logic [31:0] r;
        n = $urandom_range(20, 3);
        fill_halt();
        for (int i = 0; i < n; i++) mem[i] = rand_legal();
        r = $urandom;
        case (r[1:0])
            2'd0: mem[n] = INSN_ECALL;
            2'd1: mem[n] = INSN_EBREAK;
            2'd2: mem[n] = $urandom;
            default: mem[n] = {7'b0000001, r[14:10], r[19:15], 3'b101, r[24:20], 7'h13};
        endcase
    endtask

    // Starts the program at address 0 and scores every issue cycle against the model
    task automatic run_program(input int dly, input int rdy_pct, input int stall_cycles, output int max_run);
        int cyc;
        int first_valid;
        int run;
        int n_exp;
        int stall_left;
        bit prev_hs;
        bit done;
        exp_t e;
        build_expect();
        n_exp = q.size();
        ack_delay = dly;
        stall_left = stall_cycles;
        @(negedge clk);
        start = 1'b1;
        issue_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        first_valid = -1;
        prev_hs = 0;
        run = 0;
        max_run = 0;
        done = 0;
        while (!done && cyc < 3000) begin
            if (stall_left > 0) issue_ready = 1'b0;
            else                issue_ready = ($urandom_range(99, 0) < rdy_pct);
`ifndef INSTR_ISSUE_PREFETCH_EN
            if (prev_hs) check_eq("valid_gap", 32'(issue_valid), 32'd0);
`endif
            prev_hs = 0;
            if (issue_valid) begin
                run++;
                if (run > max_run) max_run = run;
                if (first_valid < 0) first_valid = cyc;
                if (q.size() == 0) begin
                    check_eq("extra_issue", 32'(issue_valid), 32'd0);
                end else begin
                    e = q[0];
                    check_eq("issue_pc", pc, e.pc);
                    check_eq("issue_op", 32'(op), e.op);
                    check_eq("issue_dst", 32'(dst), e.rd);
                    check_eq("issue_src1", 32'(src1), e.rs1);
                    check_eq("issue_val2", val2, e.v2);
`ifndef INSTR_ISSUE_PREFETCH_EN
                    check_eq("stall_req", 32'(imem_req), 32'd0);
`endif
                    if (issue_ready) begin
                        void'(q.pop_front());
                        prev_hs = 1;
                    end else if (stall_left > 0) begin
                        stall_left--;
                    end
                end
            end else begin
                run = 0;
            end
            if (halted || illegal) begin
                done = 1;
                check_eq("halt_valid", 32'(issue_valid), 32'd0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        issue_ready = 1'b0;
        check_eq("stopped", 32'(halted | illegal), 32'd1);
        check_eq("halted", 32'(halted), 32'(exp_kind == 1));
        check_eq("illegal", 32'(illegal), 32'(exp_kind == 2));
        check_eq("stop_pc", pc, exp_stop_pc);
        check_eq("drain", 32'(q.size()), 32'd0);
        if (n_exp > 0) check_eq("first_lat", 32'(first_valid), 32'(2 + dly));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("halt_req", 32'(imem_req), 32'd0);
            check_eq("halt_hold_pc", pc, exp_stop_pc);
        end
    endtask

    task automatic check_reset_values();
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_addr", imem_addr, 32'd0);
        check_eq("rst_valid", 32'(issue_valid), 32'd0);
        check_eq("rst_op", 32'(op), 32'(ADD));
        check_eq("rst_dst", 32'(dst), 32'd0);
        check_eq("rst_src1", 32'(src1), 32'd0);
        check_eq("rst_val2", val2, 32'd0);
        check_eq("rst_pc", pc, 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_illegal", 32'(illegal), 32'd0);
    endtask

    initial begin
        int mr;
        int pct;
        rst = 1'b1;
        start = 1'b0;
        issue_ready = 1'b0;
        force_ack = 1'b0;
        ack_delay = 0;
        fill_halt();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        // Directed program ending in ECALL at 0x10
        mem[0] = 32'h00A0_0093;
        mem[1] = 32'h0030_9093;
        mem[2] = 32'h4072_5293;
        mem[3] = 32'hFFF0_8113;
        mem[4] = INSN_ECALL;
        run_program(0, 100, 0, mr);
`ifdef INSTR_ISSUE_PREFETCH_EN
        check_eq("b2b_run", 32'(mr >= 4), 32'd1);
`endif
        run_program(0, 100, 5, mr);
        run_program(2, 100, 0, mr);

        // Illegal R-type word, restarted from HALT
        fill_halt();
        mem[0] = 32'h00A0_0093;
        mem[1] = 32'h0000_0033;
        run_program(1, 60, 0, mr);

        for (int t = 0; t < 10; t++) begin
            gen_random();
            case (t % 3)
                0:       pct = 100;
                1:       pct = 70;
                default: pct = 35;
            endcase
            run_program($urandom_range(3, 0), pct, 0, mr);
        end

        // Reset while a delayed fetch is outstanding; late acks must be ignored
        fill_halt();
        mem[0] = 32'hFFF0_8113;
        run_program(0, 100, 0, mr);
        mem[0] = 32'h00A0_0093;
        ack_delay = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_req", 32'(imem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("late_ack_valid", 32'(issue_valid), 32'd0);
            check_eq("late_ack_req", 32'(imem_req), 32'd0);
            check_eq("late_ack_pc", pc, 32'd0);
        end
        force_ack = 1'b0;
        fill_halt();
        mem[0] = 32'h00A0_0093;
        mem[1] = 32'h4072_5293;
        mem[2] = INSN_EBREAK;
        run_program(0, 100, 0, mr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
